// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction-memory loader state encoding.
package cpu_pkg;
    localparam int WORD_W       = 32;
    localparam int BYTE_W       = 8;
    localparam int INSTR_STRIDE = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_t;
endpackage

// File: rtl/word_assembler.sv
// Packs four serial bytes into a big-endian word; first byte lands in the top byte lane.
module word_assembler
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_done
);
    logic [1:0]        r_idx;
    logic [WORD_W-1:0] r_word;
    logic              r_full;
    logic              w_load;

    // A full word refuses further bytes until the owner clears it.
    assign w_load      = i_load && !r_full;
    assign o_word_done = w_load && (r_idx == 2'd3);
    assign o_word      = r_word;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_idx  <= 2'd0;
            r_word <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            // Word contents are kept so the write data stays stable after the index resets.
            r_idx  <= 2'd0;
            r_full <= 1'b0;
        end else if (w_load) begin
            case (r_idx)
                2'd0:    r_word[WORD_W-1          -: BYTE_W] <= i_byte;
                2'd1:    r_word[WORD_W-1-BYTE_W   -: BYTE_W] <= i_byte;
                2'd2:    r_word[WORD_W-1-2*BYTE_W -: BYTE_W] <= i_byte;
                default: r_word[WORD_W-1-3*BYTE_W -: BYTE_W] <= i_byte;
            endcase
            r_idx  <= r_idx + 2'd1;
            r_full <= (r_idx == 2'd3);
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction memory write port, one word-aligned write per four bytes.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH_BYTES = 104,
    parameter int CNT_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_count
);
    localparam int MAX_WORDS = DEPTH_BYTES / INSTR_STRIDE;

    loader_state_t     r_state;
    logic              r_byte_ready;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic [WORD_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_target;

    logic [CNT_W-1:0]  w_target;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_clear;
    logic              w_word_done;
    logic [WORD_W-1:0] w_word;

    // Clamping the word count keeps every write address inside the memory.
    assign w_target    = (32'(num_words) > 32'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : num_words;
    assign w_count_nxt = r_count + CNT_W'(1);
    assign w_start_ok  = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_accept    = (r_state == ST_COLLECT) && r_byte_ready && byte_valid;
    assign w_clear     = w_start_ok || (r_state == ST_WRITE);

    word_assembler u_asm (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_load      (w_accept),
        .i_byte      (byte_in),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_addr       <= '0;
            r_count      <= '0;
            r_target     <= '0;
        end else if (w_start_ok) begin
            r_target <= w_target;
            r_count  <= '0;
            r_addr   <= '0;
            r_wr_en  <= 1'b0;
            if (w_target == '0) begin
                r_state      <= ST_DONE;
                r_done       <= 1'b1;
                r_busy       <= 1'b0;
                r_byte_ready <= 1'b0;
            end else begin
                r_state      <= ST_COLLECT;
                r_done       <= 1'b0;
                r_busy       <= 1'b1;
                r_byte_ready <= 1'b1;
            end
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_word_done) begin
                        r_state      <= ST_WRITE;
                        r_byte_ready <= 1'b0;
                        r_wr_en      <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_wr_en <= 1'b0;
                    r_count <= w_count_nxt;
                    if (w_count_nxt == r_target) begin
                        // Address holds on the last word so it never passes the top of memory.
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state      <= ST_COLLECT;
                        r_addr       <= r_addr + WORD_W'(INSTR_STRIDE);
                        r_byte_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_addr;
    assign wr_data    = w_word;
    assign busy       = r_busy;
    assign done       = r_done;
    assign word_count = r_count;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: expected writes are queued by the stimulus, a negedge monitor checks each wr_en.
module tb_imem_loader;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_words = 8'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, wr_en, busy, done;
    logic [31:0] wr_addr, wr_data;
    logic [7:0]  word_count;

    imem_loader #(.DEPTH_BYTES(104), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .word_count(word_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic prev_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        wr_t e;
        if (wr_en) begin
            chk("wr_en_back_to_back", {31'd0, prev_we}, 32'd0);
            chk("wr_addr_in_range", {31'd0, (wr_addr <= 32'd100)}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=0x%0h data=0x%0h", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
            end
        end
        prev_we = wr_en;
    end

    task automatic do_start(input logic [7:0] n);
        start = 1'b1;
        num_words = n;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Present a byte, hold it until byte_ready, return at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(negedge clock);
        end
        byte_in = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n == 50) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout actual=timeout expected=accept");
        end
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap);
    endtask

    // Called in the WRITE cycle of the final word.
    task automatic after_last(input logic [7:0] cnt);
        chk("final_wr_en", {31'd0, wr_en}, 32'd1);
        chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
        @(negedge clock);
        chk("done_after_write", {31'd0, done}, 32'd1);
        chk("busy_after_write", {31'd0, busy}, 32'd0);
        chk("word_count", {24'd0, word_count}, {24'd0, cnt});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, wr_addr, 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_word_count"}, {24'd0, word_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w3 [3];
        w3[0] = 32'h04011000;
        w3[1] = 32'h0C011800;
        w3[2] = 32'h14432000;

        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        // Single word
        do_start(8'd1);
        exp_q.push_back('{addr: 32'd0, data: 32'h8001060A});
        send_word(32'h8001060A, 0);
        after_last(8'd1);

        // Three words with 0..3 cycle gaps between bytes
        do_start(8'd3);
        for (int i = 0; i < 3; i++) exp_q.push_back('{addr: 32'(4 * i), data: w3[i]});
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) send_byte(w3[i][31-8*k -: 8], (i + k) % 4);
        after_last(8'd3);

        // Clamp to memory depth
        do_start(8'd200);
        for (int i = 0; i < 26; i++)
            exp_q.push_back('{addr: 32'(4 * i),
                              data: {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}});
        for (int i = 0; i < 26; i++)
            send_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 0);
        after_last(8'd26);
        chk("clamp_last_addr", wr_addr, 32'd100);
        byte_in = 8'hAA;
        byte_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("done_not_ready", {31'd0, byte_ready}, 32'd0);
        end
        byte_valid = 1'b0;

        // Zero words
        do_start(8'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_ready", {31'd0, byte_ready}, 32'd0);
        repeat (5) @(negedge clock);

        // Reset mid-word
        do_start(8'd2);
        exp_q.push_back('{addr: 32'd0, data: 32'h11223344});
        send_word(32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        reset = 1'b0;
        @(negedge clock);
        chk_all_zero("midreset");
        reset = 1'b1;
        @(negedge clock);
        do_start(8'd1);
        exp_q.push_back('{addr: 32'd0, data: 32'hA1B2C3D4});
        send_word(32'hA1B2C3D4, 0);
        after_last(8'd1);

        // Start mid-load is ignored; start in DONE restarts
        do_start(8'd2);
        exp_q.push_back('{addr: 32'd0, data: 32'hDEADBEEF});
        exp_q.push_back('{addr: 32'd4, data: 32'hCAFE0123});
        send_word(32'hDEADBEEF, 1);
        send_byte(8'hCA, 0);
        send_byte(8'hFE, 0);
        start = 1'b1;
        num_words = 8'd7;
        @(negedge clock);
        start = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h23, 0);
        after_last(8'd2);
        do_start(8'd1);
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_count", {24'd0, word_count}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_addr", wr_addr, 32'd0);
        exp_q.push_back('{addr: 32'd0, data: 32'h5A5AA5A5});
        send_word(32'h5A5AA5A5, 2);
        after_last(8'd1);

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
